// File: rtl/hp_pkg.sv
// Shared constants for the alarm logger: record layout, source bit indices and counter widths.
package hp_pkg;

    localparam int TS_W_DFLT = 16;
    localparam int OVF_W     = 8;

    // Record layout is {src_n, src_p, ts}; ts occupies the low TS_W bits.
    localparam int SRC_P  = 0;
    localparam int SRC_N  = 1;
    localparam int TS_LSB = 0;

    function automatic int src_bit(input int ts_w, input int src);
        return ts_w + src;
    endfunction

endpackage

// File: rtl/hp_evt_fifo.sv
// Event record FIFO: synchronous push/pop, registered occupancy, pop of an empty FIFO is ignored.
// A push while full is accepted only alongside a pop; rdata reads zero when empty.
module hp_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     hp_Alarm_rst_sync,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_eff;
    logic             pop_eff;

    assign full     = (count == FULL_CNT);
    assign pop_eff  = pop & (count != '0);
    assign push_eff = push & (~full | pop_eff);

    always_ff @(posedge clk or negedge hp_Alarm_rst_sync) begin
        if (!hp_Alarm_rst_sync) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + AW'(1);
            if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_eff) - (AW+1)'(pop_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr] <= wdata;
    end

    // Masked so the record bus is quiet whenever nothing is queued.
    assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/hp_alarm_logger.sv
// Alarm edge logger: resynchronised p/n detector edges become timestamped records, valid 3 edges after sampling.
// HP_ALARM_TS_EN builds the timestamp counter (ts reads 0 otherwise); records arriving at a full, unpopped FIFO are counted and dropped.
module hp_alarm_logger
    import hp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = TS_W_DFLT
) (
    input  logic                     clk,
    input  logic                     hp_Alarm_rst_sync,
    input  logic                     alarm_p_i,
    input  logic                     alarm_n_i,
    input  logic                     arm_i,
    input  logic                     clear_i,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [TS_W+1:0]          evt_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [OVF_W-1:0]         ovf_cnt_o,
    output logic                     ovf_o
);

    localparam int P_BIT = src_bit(TS_W, SRC_P);
    localparam int N_BIT = src_bit(TS_W, SRC_N);

    logic [1:0]      sync_p;
    logic [1:0]      sync_n;
    logic            hist_p;
    logic            hist_n;
    logic [1:0]      primed;
    logic            rise_p;
    logic            rise_n;
    logic            push_req;
    logic            fifo_full;
    logic            drop;
    logic [TS_W-1:0] ts;
    logic [TS_W+1:0] rec;

    // History only follows the synchroniser once it holds real samples, so an
    // alarm already high at reset release never looks like a rising edge.
    always_ff @(posedge clk or negedge hp_Alarm_rst_sync) begin
        if (!hp_Alarm_rst_sync) begin
            sync_p <= '0;
            sync_n <= '0;
            hist_p <= 1'b1;
            hist_n <= 1'b1;
            primed <= '0;
        end else begin
            sync_p <= {sync_p[0], alarm_p_i};
            sync_n <= {sync_n[0], alarm_n_i};
            primed <= {primed[0], 1'b1};
            if (primed[1]) begin
                hist_p <= sync_p[1];
                hist_n <= sync_n[1];
            end
        end
    end

    assign rise_p   = primed[1] & sync_p[1] & ~hist_p;
    assign rise_n   = primed[1] & sync_n[1] & ~hist_n;
    assign push_req = arm_i & (rise_p | rise_n);

`ifdef HP_ALARM_TS_EN
    always_ff @(posedge clk or negedge hp_Alarm_rst_sync) begin
        if (!hp_Alarm_rst_sync) begin
            ts <= '0;
        end else if (clear_i) begin
            ts <= '0;
        end else if (arm_i) begin
            ts <= ts + TS_W'(1);
        end
    end
`else
    assign ts = '0;
`endif

    always_comb begin
        rec                   = '0;
        rec[TS_LSB +: TS_W]   = ts;
        rec[P_BIT]            = rise_p;
        rec[N_BIT]            = rise_n;
    end

    hp_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W + 2)
    ) u_fifo (
        .clk               (clk),
        .hp_Alarm_rst_sync (hp_Alarm_rst_sync),
        .clear             (clear_i),
        .push              (push_req & ~clear_i),
        .pop               (evt_ready_i & ~clear_i),
        .wdata             (rec),
        .rdata             (evt_data_o),
        .count             (count_o),
        .full              (fifo_full)
    );

    assign evt_valid_o = (count_o != '0);

    // When full, a ready consumer always frees a slot in the same cycle.
    assign drop = push_req & fifo_full & ~evt_ready_i & ~clear_i;

    always_ff @(posedge clk or negedge hp_Alarm_rst_sync) begin
        if (!hp_Alarm_rst_sync) begin
            ovf_cnt_o <= '0;
            ovf_o     <= 1'b0;
        end else if (clear_i) begin
            ovf_cnt_o <= '0;
            ovf_o     <= 1'b0;
        end else if (drop) begin
            ovf_o <= 1'b1;
            if (ovf_cnt_o != '1) ovf_cnt_o <= ovf_cnt_o + OVF_W'(1);
        end
    end

endmodule

// File: tb/tb_hp_alarm_logger.sv
// Randomised and directed bench for hp_alarm_logger against a sample-history / queue reference model.
// Expected ts fields follow HP_ALARM_TS_EN as defined for the build.
module tb_hp_alarm_logger;

    localparam int DEPTH = 8;
    localparam int TS_W  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef HP_ALARM_TS_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alarm_p_i;
    logic              alarm_n_i;
    logic              arm_i;
    logic              clear_i;
    logic              evt_valid_o;
    logic              evt_ready_i;
    logic [TS_W+1:0]   evt_data_o;
    logic [CW-1:0]     count_o;
    logic [7:0]        ovf_cnt_o;
    logic              ovf_o;

    always #5 clk = ~clk;

    hp_alarm_logger #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk               (clk),
        .hp_Alarm_rst_sync (rst_n),
        .alarm_p_i         (alarm_p_i),
        .alarm_n_i         (alarm_n_i),
        .arm_i             (arm_i),
        .clear_i           (clear_i),
        .evt_valid_o       (evt_valid_o),
        .evt_ready_i       (evt_ready_i),
        .evt_data_o        (evt_data_o),
        .count_o           (count_o),
        .ovf_cnt_o         (ovf_cnt_o),
        .ovf_o             (ovf_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per-edge alarm samples, a record queue, the timestamp and overflow counters.
    logic [TS_W+1:0] q[$];
    int              ts_m;
    int              ovf_m;
    bit              ovf_f;
    bit              hp_s[3];
    bit              hn_s[3];

    task automatic model_reset();
        q.delete();
        ts_m  = 0;
        ovf_m = 0;
        ovf_f = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hp_s[i] = 1'b1;
            hn_s[i] = 1'b1;
        end
    endtask

    // An alarm seen high at edge k after low at edge k-1 is recorded at edge k+2.
    task automatic model_edge();
        bit ev_p, ev_n, push, pop, was_full;
        int ts_field;
        ev_p     = hp_s[1] & ~hp_s[2];
        ev_n     = hn_s[1] & ~hn_s[2];
        push     = arm_i & (ev_p | ev_n);
        ts_field = TS_ON ? ts_m : 0;
        if (clear_i) begin
            q.delete();
            ts_m  = 0;
            ovf_m = 0;
            ovf_f = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            pop      = evt_ready_i && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (push) begin
                if (was_full && !pop) begin
                    ovf_f = 1'b1;
                    if (ovf_m < 255) ovf_m++;
                end else begin
                    q.push_back({ev_n, ev_p, TS_W'(ts_field)});
                end
            end
            if (arm_i) ts_m = (ts_m + 1) % (1 << TS_W);
        end
        hp_s[2] = hp_s[1]; hp_s[1] = hp_s[0]; hp_s[0] = alarm_p_i;
        hn_s[2] = hn_s[1]; hn_s[1] = hn_s[0]; hn_s[0] = alarm_n_i;
    endtask

    task automatic compare(input string ph);
        chk({ph, "_count"}, 32'(count_o), 32'(q.size()));
        chk({ph, "_valid"}, 32'(evt_valid_o), 32'(q.size() != 0));
        if (q.size() > 0) chk({ph, "_data"}, 32'(evt_data_o), 32'(q[0]));
        chk({ph, "_ovf_cnt"}, 32'(ovf_cnt_o), 32'(ovf_m));
        chk({ph, "_ovf"}, 32'(ovf_o), 32'(ovf_f));
    endtask

    // Called just after a falling edge: drive, take one rising edge, check at the next falling edge.
    task automatic step(input bit p, input bit n, input bit arm, input bit rdy, input bit clr, input string ph);
        alarm_p_i   = p;
        alarm_n_i   = n;
        arm_i       = arm;
        evt_ready_i = rdy;
        clear_i     = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare(ph);
    endtask

    task automatic do_reset(input bit p, input bit n, input string ph);
        rst_n     = 1'b0;
        alarm_p_i = p;
        alarm_n_i = n;
        #1;
        model_reset();
        compare(ph);
        chk({ph, "_data_zero"}, 32'(evt_data_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rp, rn;
        rst_n       = 1'b0;
        alarm_p_i   = 1'b0;
        alarm_n_i   = 1'b0;
        arm_i       = 1'b0;
        clear_i     = 1'b0;
        evt_ready_i = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0, 1'b0, "reset");
        compare("release");

        // Single p pulse starting while ts=5 -> record {0,1,ts=7} after the 3rd edge.
        repeat (5) step(0, 0, 1, 0, 0, "idle");
        step(1, 0, 1, 0, 0, "p1");
        step(1, 0, 1, 0, 0, "p2");
        chk("p_not_yet_valid", 32'(evt_valid_o), 32'd0);
        step(1, 0, 1, 0, 0, "p3");
        chk("p_valid_3rd", 32'(evt_valid_o), 32'd1);
        chk("p_record", 32'(evt_data_o), {26'd0, 2'b01, TS_ON ? 4'd7 : 4'd0});
        step(0, 0, 1, 1, 0, "p_drain");

        // Coincident p and n edges -> one record with both source bits.
        repeat (2) step(0, 0, 1, 0, 0, "idle");
        repeat (3) step(1, 1, 1, 0, 0, "pn");
        chk("pn_count", 32'(count_o), 32'd1);
        chk("pn_src", 32'(evt_data_o[TS_W+1:TS_W]), 32'd3);
        repeat (3) step(0, 0, 1, 1, 0, "pn_drain");

        // Ten edges into an undrained FIFO of eight.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0, 0, "fill_hi");
            step(0, 0, 1, 0, 0, "fill_lo");
        end
        repeat (2) step(0, 0, 1, 0, 0, "fill_idle");
        chk("full_count", 32'(count_o), 32'd8);
        chk("full_ovf_cnt", 32'(ovf_cnt_o), 32'd2);
        chk("full_ovf", 32'(ovf_o), 32'd1);

        // Push and pop together while full: nothing dropped.
        step(1, 0, 1, 0, 0, "fp_hi");
        step(0, 0, 1, 0, 0, "fp_lo");
        step(0, 0, 1, 1, 0, "fp_both");
        chk("fp_count", 32'(count_o), 32'd8);
        chk("fp_ovf_cnt", 32'(ovf_cnt_o), 32'd2);

        // Drain with capture disabled.
        repeat (10) step(0, 0, 0, 1, 0, "drain_disarmed");
        chk("drained", 32'(count_o), 32'd0);

        // Armed long enough for a 4-bit timestamp to wrap, then flush.
        step(0, 0, 1, 0, 1, "clr0");
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, 0, "wrap_hi");
            step(0, 0, 1, 0, 0, "wrap_lo");
            step(0, 1, 1, 1, 0, "wrap_n");
            step(0, 0, 1, 0, 0, "wrap_idle");
        end
        step(0, 0, 1, 0, 1, "clr1");
        chk("clr_count", 32'(count_o), 32'd0);
        chk("clr_ovf", 32'(ovf_o), 32'd0);
        repeat (3) step(1, 0, 1, 0, 0, "post_clr");
        chk("post_clr_rec", 32'(evt_data_o), {26'd0, 2'b01, TS_ON ? 4'd2 : 4'd0});
        repeat (2) step(0, 0, 1, 1, 0, "post_clr_drain");

        // Alarms already high across reset release.
        do_reset(1'b1, 1'b1, "rst_high");
        repeat (6) step(1, 1, 1, 0, 0, "held_high");
        chk("held_high_none", 32'(count_o), 32'd0);
        repeat (3) step(0, 0, 1, 0, 0, "held_low");

        // Reset with records in flight.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 0, "mid_hi");
            step(0, 1, 1, 0, 0, "mid_lo");
        end
        do_reset(1'b0, 1'b0, "mid_rst");
        repeat (3) step(0, 0, 1, 0, 0, "after_mid_rst");

        rp = 1'b0;
        rn = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) < 3) rp = ~rp;
            if ($urandom_range(0, 9) < 3) rn = ~rn;
            step(rp, rn, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 99) < 2, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
